// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader: framed byte-stream boot loader for instruction memory.
// Holds the CPU in reset until the program has loaded and its checksum matches.
// Revision: 1.0
// ============================================================================
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [16:0] C_DEPTH = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        w_accept;
  logic [15:0] w_len;

  assign byte_ready_o = rst_i && (state_q != S_DONE) && (state_q != S_ERR);
  assign w_accept     = byte_valid_i && byte_ready_o;
  assign w_len        = {byte_i, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (w_accept) begin
      // The checksum byte itself is compared, never folded into the running XOR.
      if (state_q != S_CSUM) begin
        xor_d = xor_q ^ byte_i;
      end
      unique case (state_q)
        S_LEN0: begin
          cnt_d[7:0] = byte_i;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          cnt_d[15:8] = byte_i;
          if ({1'b0, w_len} > C_DEPTH) begin
            state_d = S_ERR;
          end else if (w_len == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          lane_d = lane_q + 2'd1;
          asm_d  = {byte_i, asm_q[23:8]};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = {14'd0, idx_q, 2'b00};
            wdata_d = {byte_i, asm_q};
            idx_d   = idx_q + 16'd1;
            if (idx_q + 16'd1 == cnt_q) begin
              state_d = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          state_d = (byte_i == xor_q) ? S_DONE : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_LEN0;
      cnt_q   <= 16'd0;
      idx_q   <= 16'd0;
      xor_q   <= 8'd0;
      lane_q  <= 2'd0;
      asm_q   <= 24'd0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we_o      = we_q;
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;
  assign done_o    = (state_q == S_DONE);
  assign err_o     = (state_q == S_ERR);
  assign cpu_rst_o = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader: directed frames checked cycle-by-cycle against a stream model.
// Revision: 1.0
// ============================================================================
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o, we_o, cpu_rst_o, done_o, err_o;
  logic [31:0] waddr_o, wdata_o;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Frame under test and what the stream rules say about it.
  logic [7:0] fr [0:15];
  int         fr_len;
  int         n_words;
  bit         len_ok;
  int         term_len;
  bit         csum_ok;

  task automatic set_frame(input int n, input logic [127:0] v);
    logic [7:0] x;
    fr_len = n;
    for (int i = 0; i < 16; i++) fr[i] = 8'd0;
    for (int i = 0; i < n; i++) fr[i] = v[8*(n-i)-1 -: 8];
    n_words  = {fr[1], fr[0]};
    len_ok   = (n_words <= DEPTH);
    term_len = len_ok ? (3 + 4 * n_words) : 2;
    x = 8'd0;
    for (int i = 0; i < term_len - 1; i++) x ^= fr[i];
    csum_ok  = len_ok && (fr[term_len-1] == x);
  endtask

  // Monitor: k counts bytes the stream rules say have been accepted.
  int          k = 0;
  bit          just = 0;
  logic [31:0] exp_addr = 0, exp_data = 0;
  logic [63:0] wlog [$];

  always @(negedge clk) begin
    bit exp_we, exp_rdy, fin;
    if (!rst_i) begin
      chk("rst_ready", byte_ready_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_outs", {waddr_o | wdata_o}, 0);
      chk("rst_status", {done_o, err_o, cpu_rst_o}, 0);
      k = 0; just = 0; exp_addr = 0; exp_data = 0;
    end else begin
      exp_we = just && len_ok && k >= 6 && k <= 2 + 4 * n_words && ((k - 2) % 4 == 0);
      if (exp_we) begin
        exp_addr = 32'(((k - 2) / 4 - 1) * 4);
        exp_data = {fr[k-1], fr[k-2], fr[k-3], fr[k-4]};
      end
      fin     = (k >= term_len);
      exp_rdy = !fin;
      chk("we", we_o, exp_we);
      chk("waddr", waddr_o, exp_addr);
      chk("wdata", wdata_o, exp_data);
      chk("ready", byte_ready_o, exp_rdy);
      chk("done", done_o, fin && csum_ok);
      chk("err", err_o, fin && !csum_ok);
      chk("cpu_rst", cpu_rst_o, fin && csum_ok);
      if (we_o) wlog.push_back({waddr_o, wdata_o});
      just = byte_valid_i && exp_rdy;
      if (just) k++;
    end
  end

  task automatic do_reset(input int n, input logic [127:0] v);
    @(posedge clk); #2 rst_i = 1'b0;
    set_frame(n, v);
    wlog.delete();
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;
  endtask

  task automatic send(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1 byte_valid_i = 1'b0; byte_i = 8'($urandom);
        end
      end
      @(posedge clk); #1 byte_valid_i = 1'b1; byte_i = fr[i];
    end
    @(posedge clk); #1 byte_valid_i = 1'b0;
  endtask

  localparam logic [127:0] FRAME_A = {8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                                      8'h20, 8'h40, 8'h09, 8'h01, 8'h47};
  localparam logic [127:0] FRAME_BAD = {8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                                        8'h20, 8'h40, 8'h09, 8'h01, 8'h46};

  task automatic pin_frame_a(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk({tag, "_w0"}, wlog[0][63:32], 32'h0000_0000);
      chk({tag, "_d0"}, wlog[0][31:0], 32'h2008_0005);
      chk({tag, "_w1"}, wlog[1][63:32], 32'h0000_0004);
      chk({tag, "_d1"}, wlog[1][31:0], 32'h0109_4020);
    end
    chk({tag, "_final"}, {done_o, cpu_rst_o, err_o}, 3'b110);
  endtask

  initial begin
    // Two-word frame, back-to-back.
    do_reset(11, FRAME_A);
    send(0, 10, 1'b0);
    repeat (3) @(posedge clk);
    pin_frame_a("b2b");

    // Same frame with random gaps.
    do_reset(11, FRAME_A);
    send(0, 10, 1'b1);
    repeat (3) @(posedge clk);
    pin_frame_a("gaps");

    // Empty program, then a stray byte after DONE.
    do_reset(4, {8'h00, 8'h00, 8'h00, 8'h55});
    send(0, 3, 1'b0);
    repeat (3) @(posedge clk);
    chk("empty_nwrites", wlog.size(), 0);
    chk("empty_final", {done_o, cpu_rst_o, err_o}, 3'b110);

    // Checksum mismatch.
    do_reset(11, FRAME_BAD);
    send(0, 10, 1'b0);
    repeat (3) @(posedge clk);
    chk("bad_nwrites", wlog.size(), 2);
    chk("bad_final", {done_o, cpu_rst_o, err_o, byte_ready_o}, 4'b0010);

    // Oversize count followed by bytes that must be ignored.
    do_reset(5, {8'h2C, 8'h01, 8'hAA, 8'hBB, 8'hCC});
    send(0, 4, 1'b0);
    repeat (3) @(posedge clk);
    chk("big_nwrites", wlog.size(), 0);
    chk("big_final", {done_o, cpu_rst_o, err_o, byte_ready_o}, 4'b0010);

    // Reset right after the 6th byte, while the first write is on the bus.
    do_reset(11, FRAME_A);
    send(0, 5, 1'b0);
    chk("mid_pending_we", we_o, 1'b1);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_we_dropped", we_o, 1'b0);
    chk("mid_wdata", wdata_o, 32'd0);
    chk("mid_ready", byte_ready_o, 1'b0);
    chk("mid_status", {done_o, err_o, cpu_rst_o}, 3'b000);
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;
    wlog.delete();
    send(0, 10, 1'b0);
    repeat (3) @(posedge clk);
    pin_frame_a("reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
